// File: rtl/wb_core_responder.sv
// Wishbone-classic responder for the neuron cores: packs input spike words,
// assembles parameter records, triggers calculation passes and returns output spikes.
module wb_core_responder #(
    parameter int          NUM_CORE = 2,
    parameter int          PARAM_W  = 368,
    parameter logic [15:0] IMEM_HI  = 16'h8000,
    parameter logic [15:0] PARAM_HI = 16'h8002,
    parameter logic [15:0] OMEM_HI  = 16'h8004,
    parameter logic [31:0] CALC_ADR = 32'h8036_0000
) (
    input  logic                    clk_i,
    input  logic                    wb_rst_ni,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_we_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic [31:0]             wbs_adr_i,
    input  logic [31:0]             wbs_dat_i,
    output logic                    wbs_ack_o,
    output logic [31:0]             wbs_dat_o,
    output logic [NUM_CORE*256-1:0] spike_in_o,
    output logic                    param_we_o,
    output logic                    param_core_o,
    output logic [7:0]              param_neuron_o,
    output logic [PARAM_W-1:0]      param_data_o,
    output logic                    calc_start_o,
    input  logic                    calc_done_i,
    input  logic [NUM_CORE*256-1:0] spike_out_i
);

    localparam int SPK_W  = NUM_CORE * 256;
    localparam int IDX_W  = $clog2(SPK_W);
    localparam int SIDX_W = $clog2(PARAM_W);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RESP = 2'd1;
    localparam logic [1:0] ST_CALC = 2'd2;

    logic [1:0]         state_r;
    logic               start_pend_r;
    logic [31:0]        adr_r;
    logic [31:0]        wdat_r;
    logic [3:0]         sel_r;
    logic               we_r;
    logic               ack_r;
    logic [31:0]        dat_r;
    logic [SPK_W-1:0]   spike_in_r;
    logic [SPK_W-1:0]   omem_r;
    logic [PARAM_W-1:0] shadow_r;
    logic               param_we_r;
    logic               param_core_r;
    logic [7:0]         param_neuron_r;
    logic               calc_start_r;

    logic               req_s;
    logic [15:0]        imem_off_s;
    logic [15:0]        param_off_s;
    logic [15:0]        omem_off_s;
    logic               hit_imem_s;
    logic               hit_param_s;
    logic               hit_omem_s;
    logic [2:0]         word_s;
    logic [3:0]         pword_s;
    logic               calc_rd_s;
    logic               clear_s;
    logic               imem_wr_s;
    logic               param_wr_s;
    logic               commit_s;
    logic [31:0]        rdata_s;
    logic [SPK_W-1:0]   imem_next_s;
    logic [PARAM_W-1:0] shadow_next_s;

    // Decode works on the latched request so the RESP cycle sees a stable address.
    assign req_s       = wbs_cyc_i & wbs_stb_i;
    assign imem_off_s  = adr_r[31:16] - IMEM_HI;
    assign param_off_s = adr_r[31:16] - PARAM_HI;
    assign omem_off_s  = adr_r[31:16] - OMEM_HI;
    assign hit_imem_s  = imem_off_s < 16'(NUM_CORE);
    assign hit_param_s = param_off_s < 16'(NUM_CORE);
    assign hit_omem_s  = omem_off_s < 16'(NUM_CORE);
    assign word_s      = adr_r[4:2];
    assign pword_s     = adr_r[5:2];
    assign calc_rd_s   = !we_r && (adr_r == CALC_ADR);
    assign clear_s     = we_r && (adr_r == 32'd0);
    assign imem_wr_s   = we_r && hit_imem_s;
    assign param_wr_s  = we_r && hit_param_s && (pword_s <= 4'd11);
    assign commit_s    = param_wr_s && (pword_s == 4'd11);

    // Read-data mux: word 0 of a core sits at the top of its 256-bit slice.
    always_comb begin
        rdata_s = 32'd0;
        if (!we_r && hit_imem_s) begin
            rdata_s = spike_in_r[IDX_W'({imem_off_s[0], ~word_s, 5'b00000}) +: 32];
        end else if (!we_r && hit_omem_s) begin
            rdata_s = omem_r[IDX_W'({omem_off_s[0], ~word_s, 5'b00000}) +: 32];
        end else begin
            rdata_s = 32'd0;
        end
    end

    // Byte-masked merge of the write data into the spike vector and parameter shadow.
    always_comb begin
        imem_next_s   = spike_in_r;
        shadow_next_s = shadow_r;
        for (int b = 0; b < 4; b++) begin
            if (sel_r[b]) begin
                imem_next_s[IDX_W'({imem_off_s[0], ~word_s, 2'(b), 3'b000}) +: 8] = wdat_r[8*b +: 8];
            end else begin
                imem_next_s[IDX_W'({imem_off_s[0], ~word_s, 2'(b), 3'b000}) +: 8] =
                    spike_in_r[IDX_W'({imem_off_s[0], ~word_s, 2'(b), 3'b000}) +: 8];
            end
        end
        if (pword_s == 4'd11) begin
            shadow_next_s[15:0] = wdat_r[31:16];
        end else if (pword_s < 4'd11) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_r[b]) begin
                    shadow_next_s[SIDX_W'(PARAM_W - 32 - 32*int'(pword_s) + 8*b) +: 8] = wdat_r[8*b +: 8];
                end else begin
                    shadow_next_s[SIDX_W'(PARAM_W - 32 - 32*int'(pword_s) + 8*b) +: 8] =
                        shadow_r[SIDX_W'(PARAM_W - 32 - 32*int'(pword_s) + 8*b) +: 8];
                end
            end
        end else begin
            shadow_next_s = shadow_r;
        end
    end

    // Bus state machine; writes and all outputs take effect in the RESP cycle.
    always_ff @(posedge clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_r        <= ST_IDLE;
            start_pend_r   <= 1'b0;
            adr_r          <= 32'd0;
            wdat_r         <= 32'd0;
            sel_r          <= 4'd0;
            we_r           <= 1'b0;
            ack_r          <= 1'b0;
            dat_r          <= 32'd0;
            spike_in_r     <= '0;
            omem_r         <= '0;
            shadow_r       <= '0;
            param_we_r     <= 1'b0;
            param_core_r   <= 1'b0;
            param_neuron_r <= 8'd0;
            calc_start_r   <= 1'b0;
        end else begin
            ack_r        <= 1'b0;
            dat_r        <= 32'd0;
            param_we_r   <= 1'b0;
            calc_start_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_s) begin
                        adr_r   <= wbs_adr_i;
                        wdat_r  <= wbs_dat_i;
                        sel_r   <= wbs_sel_i;
                        we_r    <= wbs_we_i;
                        state_r <= ST_RESP;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RESP: begin
                    ack_r <= 1'b1;
                    dat_r <= rdata_s;
                    if (clear_s) begin
                        spike_in_r <= '0;
                    end else if (imem_wr_s) begin
                        spike_in_r <= imem_next_s;
                    end
                    if (param_wr_s) begin
                        shadow_r <= shadow_next_s;
                    end
                    if (commit_s) begin
                        param_we_r     <= 1'b1;
                        param_core_r   <= param_off_s[0];
                        param_neuron_r <= adr_r[15:8];
                    end
                    if (calc_rd_s) begin
                        start_pend_r <= 1'b1;
                        state_r      <= ST_CALC;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    // Done is only meaningful once the start pulse has gone out.
                    if (start_pend_r) begin
                        calc_start_r <= 1'b1;
                        start_pend_r <= 1'b0;
                    end else if (calc_done_i) begin
                        omem_r  <= spike_out_i;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign wbs_ack_o      = ack_r;
    assign wbs_dat_o      = dat_r;
    assign spike_in_o     = spike_in_r;
    assign param_we_o     = param_we_r;
    assign param_core_o   = param_core_r;
    assign param_neuron_o = param_neuron_r;
    assign param_data_o   = shadow_r;
    assign calc_start_o   = calc_start_r;

endmodule

// File: tb/tb_wb_core_responder.sv
// Directed bench for wb_core_responder: vector table for the bus map plus
// hand-written sequences for parameter commit, calculation stall and reset mid-calc.
module tb_wb_core_responder;

    localparam int NC = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cyc, stb, we;
    logic [3:0]      sel;
    logic [31:0]     adr, wdat;
    logic            ack;
    logic [31:0]     rdat;
    logic [NC*256-1:0] spike_in;
    logic            param_we;
    logic            param_core;
    logic [7:0]      param_neuron;
    logic [367:0]    param_data;
    logic            calc_start;
    logic            calc_done;
    logic [NC*256-1:0] spike_out;

    int total = 0;
    int bad   = 0;
    int pwe_cnt = 0;

    always #5 clk = ~clk;

    wb_core_responder dut (
        .clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .spike_in_o(spike_in), .param_we_o(param_we), .param_core_o(param_core),
        .param_neuron_o(param_neuron), .param_data_o(param_data),
        .calc_start_o(calc_start), .calc_done_i(calc_done), .spike_out_i(spike_out)
    );

    // Count every commit strobe seen.
    always @(negedge clk) begin
        if (param_we) pwe_cnt <= pwe_cnt + 1;
    end

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic w, output logic [31:0] rd, output logic got,
                        output logic pwe, output logic nack, output logic nstart);
        @(negedge clk);
        adr = a; wdat = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
        got = 1'b0; rd = 32'd0; pwe = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack) begin
                got = 1'b1; rd = rdat; pwe = param_we;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        nack = ack; nstart = calc_start;
    endtask

    initial begin
        logic [31:0] rd;
        logic got, pwe, nack, nst;
        int acks;
        int pwe_before;

        vt[0]  = '{32'h8000_0000, 32'h1122_3344, 4'hF, 1'b1, 32'h0};
        vt[1]  = '{32'h8000_001C, 32'hCAFE_F00D, 4'hF, 1'b1, 32'h0};
        vt[2]  = '{32'h8001_0004, 32'hDEAD_BEEF, 4'h3, 1'b1, 32'h0};
        vt[3]  = '{32'h8000_0000, 32'h0,         4'hF, 1'b0, 32'h1122_3344};
        vt[4]  = '{32'h8000_001C, 32'h0,         4'hF, 1'b0, 32'hCAFE_F00D};
        vt[5]  = '{32'h8001_0004, 32'h0,         4'hF, 1'b0, 32'h0000_BEEF};
        vt[6]  = '{32'h8001_0004, 32'h5566_7788, 4'hC, 1'b1, 32'h0};
        vt[7]  = '{32'h8001_0004, 32'h0,         4'hF, 1'b0, 32'h5566_BEEF};
        vt[8]  = '{32'h9000_0000, 32'h0,         4'hF, 1'b0, 32'h0};
        vt[9]  = '{32'h8002_0000, 32'h0,         4'hF, 1'b0, 32'h0};
        vt[10] = '{32'h8006_0000, 32'h0,         4'hF, 1'b0, 32'h0};
        vt[11] = '{32'h8004_0000, 32'h0,         4'hF, 1'b0, 32'h0};

        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
        adr = 32'd0; wdat = 32'd0; calc_done = 1'b0; spike_out = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_dat", 64'(rdat), 64'd0);
        chk("rst_spike_zero", 64'(spike_in == '0), 64'd1);
        chk("rst_param", 64'(param_data == '0 && !param_we), 64'd1);
        chk("rst_start", 64'(calc_start), 64'd0);

        // Bus map table.
        for (int i = 0; i < 12; i++) begin
            xfer(vt[i].adr, vt[i].dat, vt[i].sel, vt[i].we, rd, got, pwe, nack, nst);
            chk($sformatf("vec%0d_ack", i), 64'(got), 64'd1);
            chk($sformatf("vec%0d_rd", i), 64'(rd), 64'(vt[i].exp));
            chk($sformatf("vec%0d_ack_once", i), 64'(nack), 64'd0);
        end
        chk("pack_core1_w1", 64'(spike_in[256+223 -: 32]), 64'h5566_BEEF);
        chk("pack_core0_w0", 64'(spike_in[255:224]), 64'h1122_3344);
        chk("pack_core0_w7", 64'(spike_in[31:0]), 64'hCAFE_F00D);

        xfer(32'h0, 32'hFFFF_FFFF, 4'hF, 1'b1, rd, got, pwe, nack, nst);
        chk("clear_ack", 64'(got), 64'd1);
        chk("clear_zero", 64'(spike_in == '0), 64'd1);

        // Parameter record for neuron 0x2A of core 1.
        pwe_before = pwe_cnt;
        for (int k = 0; k < 12; k++) begin
            xfer(32'h8003_2A00 + 32'(4*k), (k == 11) ? 32'hABCD_1234 : 32'h1000_0000 + 32'(k),
                 4'hF, 1'b1, rd, got, pwe, nack, nst);
            chk($sformatf("param_w%0d_pwe", k), 64'(pwe), (k == 11) ? 64'd1 : 64'd0);
        end
        chk("param_pulse_count", 64'(pwe_cnt - pwe_before), 64'd1);
        chk("param_core", 64'(param_core), 64'd1);
        chk("param_neuron", 64'(param_neuron), 64'h2A);
        chk("param_w0", 64'(param_data[367:336]), 64'h1000_0000);
        chk("param_w1", 64'(param_data[335:304]), 64'h1000_0001);
        chk("param_w10", 64'(param_data[47:16]), 64'h1000_000A);
        chk("param_w11", 64'(param_data[15:0]), 64'hABCD);

        xfer(32'h8003_2A34, 32'h5555_5555, 4'hF, 1'b1, rd, got, pwe, nack, nst);
        chk("param_w13_ack", 64'(got), 64'd1);
        chk("param_w13_no_pulse", 64'(pwe_cnt - pwe_before), 64'd1);
        chk("param_w13_unchanged", 64'(param_data[15:0]), 64'hABCD);

        // Calculation: stall of a pending read, then capture.
        xfer(32'h8036_0000, 32'h0, 4'hF, 1'b0, rd, got, pwe, nack, nst);
        chk("calc_ack", 64'(got), 64'd1);
        chk("calc_rd", 64'(rd), 64'd0);
        chk("calc_start", 64'(nst), 64'd1);
        @(negedge clk);
        chk("calc_start_once", 64'(calc_start), 64'd0);
        adr = 32'h8004_0000; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        acks = 0;
        repeat (20) begin
            @(negedge clk);
            if (ack) acks++;
        end
        chk("calc_stall", 64'(acks), 64'd0);
        spike_out = '0;
        spike_out[255:224] = 32'h1234_5678;
        spike_out[511:480] = 32'hA5A5_0001;
        calc_done = 1'b1;
        @(negedge clk);
        calc_done = 1'b0;
        got = 1'b0; rd = 32'd0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack) begin
                got = 1'b1; rd = rdat;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0;
        chk("calc_pending_ack", 64'(got), 64'd1);
        chk("calc_pending_rd", 64'(rd), 64'h1234_5678);
        spike_out = '0;

        xfer(32'h8005_0000, 32'h0, 4'hF, 1'b0, rd, got, pwe, nack, nst);
        chk("omem_core1", 64'(rd), 64'hA5A5_0001);
        xfer(32'h8004_0000, 32'hFFFF_FFFF, 4'hF, 1'b1, rd, got, pwe, nack, nst);
        chk("omem_wr_ack", 64'(got), 64'd1);
        xfer(32'h8004_0000, 32'h0, 4'hF, 1'b0, rd, got, pwe, nack, nst);
        chk("omem_wr_ignored", 64'(rd), 64'h1234_5678);

        // Reset in the middle of a calculation.
        xfer(32'h8000_0000, 32'h0000_0001, 4'hF, 1'b1, rd, got, pwe, nack, nst);
        xfer(32'h8036_0000, 32'h0, 4'hF, 1'b0, rd, got, pwe, nack, nst);
        chk("rcalc_start", 64'(nst), 64'd1);
        spike_out = '1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rcalc_ack", 64'(ack), 64'd0);
        chk("rcalc_spike_zero", 64'(spike_in == '0), 64'd1);
        chk("rcalc_param_zero", 64'(param_data == '0 && !param_core && param_neuron == 8'd0), 64'd1);
        chk("rcalc_start_zero", 64'(calc_start), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        calc_done = 1'b1;
        @(negedge clk);
        calc_done = 1'b0;
        spike_out = '0;
        xfer(32'h8004_0000, 32'h0, 4'hF, 1'b0, rd, got, pwe, nack, nst);
        chk("rcalc_idle_ack", 64'(got), 64'd1);
        chk("rcalc_omem0", 64'(rd), 64'd0);
        xfer(32'h8005_001C, 32'h0, 4'hF, 1'b0, rd, got, pwe, nack, nst);
        chk("rcalc_omem1", 64'(rd), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_core_responder.md
# wb_core_responder

Wishbone-classic responder placed between the Caravel-style user bus and the neuron cores. It decodes the core address map and packs the 32-bit spike words into one 256-bit input vector per core. It also assembles the 368-bit neuron parameter records, launches a calculation pass when the trigger address is read, and captures each core's 256-bit output spike vector so the bus can read it back.

## Interface
Parameters:
- NUM_CORE, 2, number of cores served (legal 1..2)
- PARAM_W, 368, neuron parameter record width
- IMEM_HI, 16'h8000, adr[31:16] of core 0 input-spike window
- PARAM_HI, 16'h8002, adr[31:16] of core 0 parameter window
- OMEM_HI, 16'h8004, adr[31:16] of core 0 output-spike window
- CALC_ADR, 32'h8036_0000, calculation trigger address

Ports:
- clk_i  in  1  clock; all logic on rising edge
- wb_rst_ni  in  1  asynchronous, active-low reset
- wbs_cyc_i / wbs_stb_i / wbs_we_i  in  1 each  Wishbone cycle, strobe, write enable
- wbs_sel_i  in  4  byte enables
- wbs_adr_i / wbs_dat_i  in  32 each  address, write data
- wbs_ack_o  out  1  one-cycle acknowledge
- wbs_dat_o  out  32  read data; valid only while ack is high, 0 otherwise
- spike_in_o  out  NUM_CORE*256  input spikes; core c occupies [256c+255:256c]
- param_we_o  out  1  one-cycle commit strobe for a parameter record
- param_core_o  out  1  target core of the commit
- param_neuron_o  out  8  target neuron of the commit
- param_data_o  out  PARAM_W  assembled parameter record
- calc_start_o  out  1  one-cycle start pulse to the cores
- calc_done_i  in  1  cores finished; spike_out_i is valid in this cycle
- spike_out_i  in  NUM_CORE*256  output spikes from the cores

## Operation
Address decode uses hi = adr[31:16]. Core index c = hi − window base, and c must be < NUM_CORE.
- **IMEM (write):** word w = adr[4:2] writes spike_in_o core c bits [255−32w −: 32], honouring sel per byte. Reads return the stored word.
- **CLEAR:** a write to address 0x0000_0000 zeroes every spike_in_o bit. The data value is ignored.
- **PARAM (write):** neuron = adr[15:8], word k = adr[5:2].
  - k = 0..10 writes shadow bits [367−32k −: 32], byte-masked.
  - k = 11 writes shadow [15:0] from dat_i[31:16], then commits.
  - k = 12..15: the access is acknowledged and the write ignored.
  - Reads of the PARAM window return 0.
- **OMEM (read):** word w = adr[4:2] returns omem core c bits [255−32w −: 32]. Writes are acknowledged and ignored.
- **CALC (read of CALC_ADR):** returns 0 and starts a calculation. A write to CALC_ADR is acknowledged and ignored.
- **Unmapped address:** acknowledged, read data 0, writes ignored. The bus never hangs.

State machine:
- **IDLE:** if cyc&stb, latch the request, perform the write, select read data, and go to RESP.
- **RESP:** ack_o = 1. Go to CALC if the latched request was a CALC read, otherwise go to IDLE.
- **CALC:** calc_start_o = 1 for the first cycle only. New requests are not accepted: stb is held and ack is withheld. When calc_done_i is high, latch spike_out_i into omem and go to IDLE.

Commit rule:
- param_we_o pulses during the RESP cycle of a word-11 write.
- param_data_o equals the shadow including that word.
- param_core_o and param_neuron_o come from that word-11 address.
- The shadow is shared and is not cleared after a commit.

Other rules:
- calc_done_i is ignored in IDLE and RESP.
- omem holds its contents until the next calc_done_i.

## Timing
- **Reset values:** ack_o, dat_o, spike_in_o, param_*_o, calc_start_o, shadow and omem all 0; state IDLE. This holds also when reset is asserted mid-CALC: the calculation is abandoned and a late calc_done_i is ignored.
- **Handshake:** a request sampled at edge N gives ack_o high for exactly edge N+1 to N+2.
  - An IMEM or CLEAR write is visible on spike_in_o from edge N+1.
  - The master must drop stb after seeing ack. If stb is still high in IDLE, it is treated as a new request.
  - Peak rate is one access per 2 cycles.
- **CALC read:** ack at N+1, calc_start_o at N+2, earliest new request accepted the edge after calc_done_i.
- If calc_done_i and a pending stb arrive in the same CALC cycle, the omem capture completes first. The request is accepted in IDLE on the next edge, so its read returns the new omem data.

## Test plan
- **Reset mid-calc:** assert reset during CALC → all outputs 0, state IDLE, omem 0; a following calc_done_i pulse leaves omem at 0.
- **IMEM pack and clear:**
  - Write 0x8001_0004 = 0xDEADBEEF with sel = 4'b0011 → spike_in_o[256+223 −: 32] = 0x0000BEEF, ack for exactly one cycle.
  - Write 0x0 → spike_in_o all zero.
- **Parameter commit:** write words 0..11 of neuron 0x2A, core 1 (base 0x8003_2A00), using data 0x1000_0000+k and word 11 = 0xABCD_1234.
  - Exactly one param_we_o pulse, in the ack cycle of word 11.
  - param_core_o = 1, param_neuron_o = 0x2A.
  - param_data_o[367:336] = 0x1000_0000 and [15:0] = 0xABCD.
- **Calculation:** read 0x8036_0000 → ack, dat_o 0, then calc_start_o one cycle later.
  - A read of 0x8004_0000 issued meanwhile stays unacknowledged for 20 cycles.
  - Drive calc_done_i with core 0 spike_out_i[255:224] = 0x1234_5678 → the pending read acks with 0x1234_5678 on the next cycle.
- **Unmapped and ignored accesses:** read 0x9000_0000 → ack, data 0. Write to the OMEM window → ack, omem unchanged. Write PARAM word 13 → ack, no param_we_o.
